sram_fill_demux: RTL and testbench

SRAM_FILL_DEMUX -- requirements
Module: sram_fill_demux

---
 rtl/sram_fill_demux.sv | 163 ++++++++++++++++
 tb/tb_sram_fill_demux.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fill_demux.sv
// sram_fill_demux: streams DDR read beats into a banked SRAM, rotating
// across the enabled banks and bumping the word address once per lap.
module sram_fill_demux (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [18:0]  base_addr,
  input  logic [15:0]  bank_mask,
  input  logic [3:0]   last_valid_bytes,
  input  logic         ddr_rvalid,
  input  logic [127:0] ddr_rdata,
  input  logic         ddr_rlast,
  output logic         ddr_rready,
  input  logic         sram_ready,
  output logic [15:0]  sram_we,
  output logic [18:0]  sram_addr,
  output logic [127:0] sram_wdata,
  output logic [15:0]  sram_be,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [15:0]  beat_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [15:0] mask_q;
  logic [3:0]  lvb_q;
  logic [18:0] addr_q;
  logic [3:0]  ptr_q;

  logic        full;
  logic        accept;
  logic        start_ok;
  logic        start_bad;
  logic        fin;

  logic [3:0]  ptr_nxt;
  logic        wrap;
  logic [4:0]  scan;
  logic        found;
  logic [3:0]  ptr_lo;
  logic [15:0] last_be;

  assign full       = |sram_we;
  assign busy       = (state_q != IDLE);
  assign ddr_rready = (state_q == XFER) && (!full || sram_ready);
  assign accept     = ddr_rvalid && ddr_rready;

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    fin       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (|bank_mask) begin
            start_ok = 1'b1;
            state_d  = XFER;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      XFER: begin
        if (accept && ddr_rlast) state_d = DRAIN;
      end
      DRAIN: begin
        if (full && sram_ready) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next enabled bank above the pointer; carry out of bit 4 marks a lap.
  always_comb begin
    ptr_nxt = ptr_q;
    wrap    = 1'b1;
    found   = 1'b0;
    scan    = '0;
    for (int i = 1; i <= 16; i++) begin
      scan = {1'b0, ptr_q} + 5'(i);
      if (!found && mask_q[scan[3:0]]) begin
        found   = 1'b1;
        ptr_nxt = scan[3:0];
        wrap    = scan[4];
      end
    end
  end

  always_comb begin
    ptr_lo = '0;
    for (int i = 15; i >= 0; i--) begin
      if (bank_mask[i]) ptr_lo = 4'(i);
    end
  end

  always_comb begin
    last_be = 16'hFFFF;
    if (lvb_q != 4'd0) last_be = (16'd1 << lvb_q) - 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= start_bad | fin;
      err     <= start_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= '0;
      lvb_q    <= '0;
      addr_q   <= '0;
      ptr_q    <= '0;
      beat_cnt <= '0;
    end else if (start_ok) begin
      mask_q   <= bank_mask;
      lvb_q    <= last_valid_bytes;
      addr_q   <= base_addr;
      ptr_q    <= ptr_lo;
      beat_cnt <= '0;
    end else if (accept) begin
      ptr_q <= ptr_nxt;
      if (wrap) addr_q <= addr_q + 19'd1;
      if (beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
    end
  end

  // Single-entry output stage; payload holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_we    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_be    <= '0;
    end else if (accept) begin
      sram_we    <= 16'd1 << ptr_q;
      sram_addr  <= addr_q;
      sram_wdata <= ddr_rdata;
      sram_be    <= ddr_rlast ? last_be : 16'hFFFF;
    end else if (sram_ready) begin
      sram_we    <= '0;
    end
  end

endmodule

// File: tb/tb_sram_fill_demux.sv
// tb_sram_fill_demux: random and directed fills against a bank/lap
// model, with a scoreboard monitor on the SRAM write port.
module tb_sram_fill_demux;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [18:0]  base_addr;
  logic [15:0]  bank_mask;
  logic [3:0]   lvb;
  logic         ddr_rvalid;
  logic [127:0] ddr_rdata;
  logic         ddr_rlast;
  logic         ddr_rready;
  logic         sram_ready;
  logic [15:0]  sram_we;
  logic [18:0]  sram_addr;
  logic [127:0] sram_wdata;
  logic [15:0]  sram_be;
  logic         busy;
  logic         done;
  logic         err;
  logic [15:0]  beat_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_fire = 0;
  int rdy_pct = 100;

  logic [178:0] exp_q[$];

  sram_fill_demux dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .base_addr        (base_addr),
    .bank_mask        (bank_mask),
    .last_valid_bytes (lvb),
    .ddr_rvalid       (ddr_rvalid),
    .ddr_rdata        (ddr_rdata),
    .ddr_rlast        (ddr_rlast),
    .ddr_rready       (ddr_rready),
    .sram_ready       (sram_ready),
    .sram_we          (sram_we),
    .sram_addr        (sram_addr),
    .sram_wdata       (sram_wdata),
    .sram_be          (sram_be),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .beat_cnt         (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input bit ok,
                     input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  initial begin
    sram_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      sram_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  always @(negedge clk) begin : mon
    logic [178:0] act;
    logic [178:0] e;
    logic [178:0] held;
    bit prev_hs;
    bit prev_stall;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      prev_hs = 1'b0;
      prev_stall = 1'b0;
    end else begin
      act = {sram_we, sram_addr, sram_wdata, sram_be};
      if (prev_hs)
        chk("latency", sram_we != 0, 256'(sram_we), 256'(1));
      if (prev_stall)
        chk("hold", act == held, 256'(act), 256'(held));
      if (sram_we != 0 && sram_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", 1'b0, 256'(act), 256'(0));
        end else begin
          e = exp_q.pop_front();
          chk("write", act == e, 256'(act), 256'(e));
        end
        last_fire = cyc;
      end
      if (sram_we != 0 && !sram_ready)
        chk("rready_stall", !ddr_rready, 256'(ddr_rready), 256'(0));
      prev_hs = ddr_rvalid && ddr_rready;
      prev_stall = (sram_we != 0) && !sram_ready;
      held = act;
    end
  end

  // Caller sits just after a rising edge; start is driven immediately.
  task automatic run_xfer(input logic [18:0] base, input logic [15:0] mask,
                          input logic [3:0] lv, input int n, input int vpct,
                          input bit mid, input int abort_at);
    int banks[$];
    logic [127:0] data[$];
    int k;
    int budget;
    bit hs;
    bit mid_done;
    bit got;
    for (int b = 0; b < 16; b++)
      if (mask[b]) banks.push_back(b);
    for (int i = 0; i < n; i++)
      data.push_back({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < n; i++) begin
      logic [15:0] we;
      logic [15:0] be;
      logic [18:0] a;
      we = 16'd1 << banks[i % banks.size()];
      a = base + 19'(i / banks.size());
      be = 16'hFFFF;
      if (i == n - 1 && lv != 0) begin
        be = '0;
        for (int j = 0; j < int'(lv); j++) be[j] = 1'b1;
      end
      exp_q.push_back({we, a, data[i], be});
    end

    start = 1'b1;
    base_addr = base;
    bank_mask = mask;
    lvb = lv;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_xfer", busy, 256'(busy), 256'(1));

    k = 0;
    budget = 0;
    mid_done = 1'b0;
    while (k < n && !(abort_at > 0 && k == abort_at) && budget < 5000) begin
      ddr_rvalid = ($urandom_range(99) < vpct);
      ddr_rdata = data[k];
      ddr_rlast = (k == n - 1);
      start = 1'b0;
      if (mid && k == 1 && !mid_done) begin
        mid_done = 1'b1;
        start = 1'b1;
        base_addr = ~base;
        bank_mask = 16'($urandom) | 16'h0100;
        lvb = 4'($urandom);
      end
      @(negedge clk);
      hs = ddr_rvalid && ddr_rready;
      @(posedge clk);
      #1;
      if (hs) k++;
      budget++;
    end
    ddr_rvalid = 1'b0;
    ddr_rlast = 1'b0;
    start = 1'b0;
    if (budget >= 5000)
      chk("beat_timeout", 1'b0, 256'(k), 256'(n));

    if (abort_at > 0 && k == abort_at) begin
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_outs_zero",
          {sram_we, sram_addr, sram_wdata, sram_be, busy, done, err,
           beat_cnt, ddr_rready} == '0,
          256'({sram_we, sram_addr, sram_wdata, sram_be, busy, done, err,
                beat_cnt, ddr_rready}), 256'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (done) got = 1'b1;
      end
      chk("abort_no_done", !got, 256'(got), 256'(0));
    end else begin
      got = 1'b0;
      for (int c = 0; c < 500 && !got; c++) begin
        @(negedge clk);
        #1;
        if (done) got = 1'b1;
      end
      chk("done_seen", got, 256'(got), 256'(1));
      if (got) begin
        chk("beat_cnt", beat_cnt == 16'(n), 256'(beat_cnt), 256'(n));
        chk("idle_at_done", !busy && !err, 256'({busy, err}), 256'(0));
        chk("sb_drained", exp_q.size() == 0, 256'(exp_q.size()), 256'(0));
        chk("done_lat", cyc == last_fire + 1, 256'(cyc), 256'(last_fire + 1));
        @(negedge clk);
        #1;
        chk("done_pulse", !done, 256'(done), 256'(0));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    bank_mask = '0;
    lvb = '0;
    ddr_rvalid = 1'b0;
    ddr_rdata = '0;
    ddr_rlast = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_outs",
        {sram_we, sram_addr, sram_wdata, sram_be, done, err, beat_cnt} == '0,
        256'({sram_we, sram_addr, sram_wdata, sram_be, done, err, beat_cnt}),
        256'(0));
    chk("rst_busy", !busy && !ddr_rready, 256'({busy, ddr_rready}), 256'(0));

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_xfer(19'h00100, 16'h0003, 4'd0, 4, 100, 1'b0, 0);
    run_xfer(19'h7FFFF, 16'h8001, 4'd0, 3, 100, 1'b0, 0);
    run_xfer(19'h01234, 16'h0010, 4'd5, 1, 100, 1'b0, 0);
    run_xfer(19'h01234, 16'h0010, 4'd0, 1, 100, 1'b0, 0);

    ddr_rvalid = 1'b1;
    #1;
    chk("rready_idle", !ddr_rready, 256'(ddr_rready), 256'(0));
    ddr_rvalid = 1'b0;
    start = 1'b1;
    base_addr = 19'h12345;
    bank_mask = 16'h0000;
    lvb = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("err_pulse", err && done && !busy, 256'({err, done, busy}),
        256'(3'b110));
    @(posedge clk);
    #1;
    chk("err_clear", !err && !done && !busy, 256'({err, done, busy}),
        256'(0));

    fork
      run_xfer(19'h00200, 16'h0421, 4'd0, 8, 100, 1'b0, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        rdy_pct = 0;
        repeat (3) @(posedge clk);
        #1;
        rdy_pct = 100;
      end
    join

    run_xfer(19'h03000, 16'h00F0, 4'd9, 6, 100, 1'b1, 0);
    run_xfer(19'h0ABCD, 16'h0030, 4'd0, 4, 100, 1'b0, 2);
    run_xfer(19'h05000, 16'h0030, 4'd7, 4, 100, 1'b0, 0);

    for (int t = 0; t < 24; t++) begin
      logic [15:0] m;
      logic [18:0] b;
      int nb;
      if (t % 3 == 0) m = 16'd1 << $urandom_range(15);
      else m = 16'($urandom_range(1, 65535));
      if (t % 4 == 0) b = 19'h7FFFF - 19'($urandom_range(3));
      else b = 19'($urandom);
      nb = $urandom_range(1, 12);
      rdy_pct = $urandom_range(30, 100);
      run_xfer(b, m, 4'($urandom), nb, $urandom_range(40, 100),
               (nb >= 3) && ($urandom_range(1) == 1), 0);
    end
    rdy_pct = 100;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
